// File: rtl/ledtoggle_pkg.sv
// Shared constants for the LED blinker: register map, CONTROL/STATUS bit
// positions and the run-state encoding.
package ledtoggle_pkg;

  localparam logic [2:0] ADDR_STATUS  = 3'd0;
  localparam logic [2:0] ADDR_CONTROL = 3'd1;
  localparam logic [2:0] ADDR_DIVIDER = 3'd2;
  localparam logic [2:0] ADDR_COUNT   = 3'd3;
  localparam logic [2:0] ADDR_PATTERN = 3'd4;
  localparam logic [2:0] ADDR_LED     = 3'd5;
  localparam logic [2:0] ADDR_TICKS   = 3'd6;

  localparam int STATUS_BUSY_BIT = 0;
  localparam int STATUS_DONE_BIT = 1;

  localparam int CTRL_IRQ_EN_BIT = 0;
  localparam int CTRL_CONT_BIT   = 1;
  localparam int CTRL_START_BIT  = 2;
  localparam int CTRL_STOP_BIT   = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ledtoggle_edge_detect.sv
// Rising-edge detector: one-cycle pulse when sig_i goes from low to high.
module ledtoggle_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic sig_i,
  output logic pulse_o
);

  logic sig_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign pulse_o = sig_i & ~sig_q;

endmodule

// File: rtl/ledtoggle_led_blinker.sv
// Avalon-MM LED blinker: XORs a pattern into the LED register every DIVIDER
// timer ticks, either for COUNT steps (one-shot) or indefinitely.
module ledtoggle_led_blinker
  import ledtoggle_pkg::*;
#(
  parameter int LED_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [15:0]      writedata,
  input  logic             tick_in,
  output logic [15:0]      readdata,
  output logic [LED_W-1:0] led,
  output logic             irq
);

  state_e           state_q;
  logic             done_q;
  logic             irq_en_q;
  logic             cont_q;
  logic [15:0]      divider_q;
  logic [15:0]      count_q;
  logic [LED_W-1:0] pattern_q;
  logic [LED_W-1:0] led_q;
  logic [15:0]      ticks_q;
  logic [15:0]      div_cnt_q;
  logic [15:0]      steps_left_q;
  logic [15:0]      readdata_q;

  logic        tick;
  logic        wr_en;
  logic        start_req;
  logic        stop_req;
  logic [15:0] div_last;
  logic [15:0] ticks_d;
  logic [15:0] readdata_d;

  ledtoggle_edge_detect u_tick_edge (
    .clk     (clk),
    .reset_n (reset_n),
    .sig_i   (tick_in),
    .pulse_o (tick)
  );

  assign wr_en     = chipselect & ~write_n;
  assign start_req = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_START_BIT];
  assign stop_req  = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_STOP_BIT];
  // A DIVIDER of 0 behaves as 1, so the last count index is 0 in both cases.
  assign div_last  = (divider_q == 16'd0) ? 16'd0 : divider_q - 16'd1;
  assign ticks_d   = ticks_q + {15'd0, tick};

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS: begin
        readdata_d[STATUS_BUSY_BIT] = (state_q == ST_RUN);
        readdata_d[STATUS_DONE_BIT] = done_q;
      end
      ADDR_CONTROL: begin
        readdata_d[CTRL_IRQ_EN_BIT] = irq_en_q;
        readdata_d[CTRL_CONT_BIT]   = cont_q;
      end
      ADDR_DIVIDER: readdata_d = divider_q;
      ADDR_COUNT:   readdata_d = count_q;
      ADDR_PATTERN: readdata_d = 16'(pattern_q);
      ADDR_LED:     readdata_d = 16'(led_q);
      ADDR_TICKS:   readdata_d = ticks_q;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      cont_q       <= 1'b0;
      divider_q    <= 16'd1;
      count_q      <= 16'd0;
      pattern_q    <= LED_W'(1);
      led_q        <= '0;
      ticks_q      <= 16'd0;
      div_cnt_q    <= 16'd0;
      steps_left_q <= 16'd0;
      readdata_q   <= 16'd0;
    end else begin
      readdata_q <= readdata_d;
      ticks_q    <= ticks_d;

      if (wr_en) begin
        case (address)
          ADDR_STATUS:  done_q <= 1'b0;
          ADDR_CONTROL: begin
            irq_en_q <= writedata[CTRL_IRQ_EN_BIT];
            cont_q   <= writedata[CTRL_CONT_BIT];
          end
          ADDR_DIVIDER: divider_q <= writedata;
          ADDR_COUNT:   count_q   <= writedata;
          ADDR_PATTERN: pattern_q <= writedata[LED_W-1:0];
          default: ;
        endcase
      end

      // Sequencer; placed after the STATUS clear so a done set wins.
      if (stop_req) begin
        state_q <= ST_IDLE;
      end else if (start_req) begin
        state_q      <= ST_RUN;
        div_cnt_q    <= 16'd0;
        steps_left_q <= count_q;
      end else if (state_q == ST_RUN) begin
        if (!cont_q && steps_left_q == 16'd0) begin
          state_q <= ST_IDLE;
          done_q  <= 1'b1;
        end else if (tick) begin
          if (div_cnt_q >= div_last) begin
            div_cnt_q <= 16'd0;
            led_q     <= led_q ^ pattern_q;
            if (!cont_q) begin
              steps_left_q <= steps_left_q - 16'd1;
              if (steps_left_q == 16'd1) begin
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
              end
            end
          end else begin
            div_cnt_q <= div_cnt_q + 16'd1;
          end
        end
      end

      // Software LED write overrides a step in the same cycle.
      if (wr_en && address == ADDR_LED) begin
        led_q <= writedata[LED_W-1:0];
      end
    end
  end

  assign readdata = readdata_q;
  assign led      = led_q;
  assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_ledtoggle_led_blinker.sv
// Directed bench for the LED blinker: register access, one-shot and
// continuous runs, tick edge detection, TICKS wrap and reset abort.
module tb_ledtoggle_led_blinker;
  import ledtoggle_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        tick_in;
  logic [15:0] readdata;
  logic [7:0]  led;
  logic        irq;

  int n_checks;
  int n_fail;
  int n_ticks;
  logic [15:0] rd;

  ledtoggle_led_blinker #(.LED_W(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .tick_in    (tick_in),
    .readdata   (readdata),
    .led        (led),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [15:0] d);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  task automatic tick_pulse();
    tick_in = 1'b1;
    @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    n_ticks++;
  endtask

  initial begin
    n_checks = 0; n_fail = 0; n_ticks = 0;
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 16'd0; tick_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_led", led, 8'h00);
    check("rst_irq", irq, 1'b0);
    check("rst_readdata", readdata, 16'h0000);
    reset_n = 1'b1;
    @(negedge clk);
    bus_read(ADDR_STATUS, rd);  check("rst_status", rd, 16'h0000);
    bus_read(ADDR_CONTROL, rd); check("rst_control", rd, 16'h0000);
    bus_read(ADDR_DIVIDER, rd); check("rst_divider", rd, 16'h0001);
    bus_read(ADDR_COUNT, rd);   check("rst_count", rd, 16'h0000);
    bus_read(ADDR_PATTERN, rd); check("rst_pattern", rd, 16'h0001);
    bus_read(ADDR_TICKS, rd);   check("rst_ticks", rd, 16'h0000);

    // One-shot: DIVIDER=3, COUNT=2, PATTERN=0x0F
    bus_write(ADDR_DIVIDER, 16'd3);
    bus_write(ADDR_COUNT, 16'd2);
    bus_write(ADDR_PATTERN, 16'h000F);
    bus_write(ADDR_LED, 16'h0000);
    bus_write(ADDR_CONTROL, 16'h0004);
    bus_read(ADDR_STATUS, rd);  check("os_busy", rd, 16'h0001);
    for (int i = 1; i <= 6; i++) begin
      tick_pulse();
      check($sformatf("os_led_t%0d", i), led, (i >= 3 && i < 6) ? 8'h0F : 8'h00);
    end
    bus_read(ADDR_STATUS, rd);  check("os_status_done", rd, 16'h0002);
    check("os_irq_masked", irq, 1'b0);

    // One-shot with irq_en
    bus_write(ADDR_STATUS, 16'h0000);
    bus_write(ADDR_CONTROL, 16'h0005);
    for (int i = 1; i <= 5; i++) tick_pulse();
    check("irq_before_t6", irq, 1'b0);
    check("irq_led_t5", led, 8'h0F);
    tick_in = 1'b1;
    @(negedge clk);
    check("irq_after_t6", irq, 1'b1);
    check("irq_led_t6", led, 8'h00);
    tick_in = 1'b0;
    @(negedge clk);
    n_ticks++;
    bus_write(ADDR_STATUS, 16'h0000);
    check("irq_cleared", irq, 1'b0);

    // Continuous, DIVIDER=0
    bus_write(ADDR_DIVIDER, 16'd0);
    bus_write(ADDR_PATTERN, 16'h0001);
    bus_write(ADDR_LED, 16'h0000);
    bus_write(ADDR_CONTROL, 16'h0006);
    for (int i = 1; i <= 5; i++) begin
      tick_pulse();
      check($sformatf("cont_led_t%0d", i), led, (i % 2 == 1) ? 8'h01 : 8'h00);
    end
    bus_read(ADDR_STATUS, rd);  check("cont_status", rd, 16'h0001);
    bus_write(ADDR_CONTROL, 16'h0008);
    bus_read(ADDR_STATUS, rd);  check("cont_stopped", rd, 16'h0000);
    tick_pulse();
    tick_pulse();
    check("cont_no_toggle", led, 8'h01);

    // TICKS: held-high input counts once, and wraps
    bus_read(ADDR_TICKS, rd);   check("ticks_count", rd, n_ticks[15:0]);
    tick_in = 1'b1;
    repeat (10) @(negedge clk);
    tick_in = 1'b0;
    @(negedge clk);
    n_ticks++;
    bus_read(ADDR_TICKS, rd);   check("ticks_held", rd, n_ticks[15:0]);
    force dut.ticks_q = 16'hFFFF;
    @(negedge clk);
    release dut.ticks_q;
    bus_read(ADDR_TICKS, rd);   check("ticks_at_max", rd, 16'hFFFF);
    tick_pulse();
    bus_read(ADDR_TICKS, rd);   check("ticks_wrap", rd, 16'h0000);

    // COUNT=0 one-shot, start+stop together
    bus_write(ADDR_COUNT, 16'd0);
    bus_write(ADDR_LED, 16'h0033);
    bus_write(ADDR_CONTROL, 16'h0004);
    @(negedge clk);
    bus_read(ADDR_STATUS, rd);  check("cnt0_done", rd, 16'h0002);
    check("cnt0_led", led, 8'h33);
    bus_write(ADDR_STATUS, 16'h0000);
    bus_write(ADDR_CONTROL, 16'h000C);
    @(negedge clk);
    bus_read(ADDR_STATUS, rd);  check("startstop_idle", rd, 16'h0000);

    // LED write beats a same-cycle step; reset aborts a run
    bus_write(ADDR_DIVIDER, 16'd1);
    bus_write(ADDR_PATTERN, 16'h000F);
    bus_write(ADDR_LED, 16'h0000);
    bus_write(ADDR_COUNT, 16'd5);
    bus_write(ADDR_CONTROL, 16'h0005);
    tick_in = 1'b1;
    bus_write(ADDR_LED, 16'h00AA);
    tick_in = 1'b0;
    @(negedge clk);
    check("ledwr_override", led, 8'hAA);
    tick_pulse();
    check("ledwr_next_step", led, 8'hA5);
    address = ADDR_LED;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrun_led", led, 8'h00);
    check("midrun_readdata", readdata, 16'h0000);
    check("midrun_irq", irq, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(ADDR_STATUS, rd);  check("midrun_status", rd, 16'h0000);
    bus_read(ADDR_CONTROL, rd); check("midrun_control", rd, 16'h0000);
    bus_read(ADDR_DIVIDER, rd); check("midrun_divider", rd, 16'h0001);
    bus_read(ADDR_COUNT, rd);   check("midrun_count", rd, 16'h0000);
    bus_read(ADDR_PATTERN, rd); check("midrun_pattern", rd, 16'h0001);
    tick_pulse();
    check("midrun_no_step", led, 8'h00);
    bus_read(ADDR_TICKS, rd);   check("midrun_ticks", rd, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ledtoggle_led_blinker.md
LEDTOGGLE_LED_BLINKER -- requirements
Module: ledtoggle_led_blinker

Interface
REQ-001 SHALL have `clk`, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have `reset_n`, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have `address`, input, 3 bits: Avalon-MM slave word address.
REQ-004 SHALL have `chipselect`, input, 1 bit: slave select.
REQ-005 SHALL have `write_n`, input, 1 bit: active-low write strobe; write = `chipselect` & ~`write_n`.
REQ-006 SHALL have `writedata`, input, 16 bits: write data.
REQ-007 SHALL have `tick_in`, input, 1 bit: level from the system-clock timer's `irq`, same clock domain.
REQ-008 SHALL have `readdata`, output, 16 bits: registered read data.
REQ-009 SHALL have `led`, output, 8 bits: LED drive, registered.
REQ-010 SHALL have `irq`, output, 1 bit: done interrupt.
REQ-011 SHALL take parameter `LED_W` = 8: LED width, legal range 1..16.

Function
REQ-012 SHALL use this register map; unlisted bits read 0:
- 0 STATUS: bit0 = busy (read-only), bit1 = done; any write clears done.
- 1 CONTROL: bit0 = irq_en, bit1 = continuous; write bit2 = start, write bit3 = stop. Bits 2 and 3 are not stored.
- 2 DIVIDER: ticks per step; value 0 behaves as 1.
- 3 COUNT: number of steps in a one-shot run.
- 4 PATTERN: XOR mask applied to `led` at each step.
- 5 LED: read/write of the `led` register.
- 6 TICKS: read-only, free-running 16-bit count of ticks, wraps 0xFFFF->0.
REQ-013 SHALL present the read mux value on `readdata` one cycle after the address is applied, every cycle, with no chipselect qualification.
REQ-014 SHALL detect tick = `tick_in` & ~`tick_in`-delayed (rising edge); a held-high `tick_in` counts once.
REQ-015 SHALL implement FSM states IDLE and RUN; `busy` = (state == RUN).
REQ-016 SHALL act on a start write as follows: clear div_cnt, load steps_left = COUNT, enter RUN next cycle.
REQ-017 SHALL, on a start write while in RUN, restart (reload div_cnt and steps_left).
REQ-018 SHALL, on a stop write, go to IDLE with done unchanged; stop wins when start and stop are written together.
REQ-019 SHALL, on a one-shot start with COUNT = 0, return to IDLE and set done one cycle later with no step.
REQ-020 SHALL, on a tick in RUN, increment div_cnt while div_cnt < effective DIVIDER - 1.
REQ-021 SHALL, on a tick in RUN with div_cnt = effective DIVIDER - 1, perform a step:
- div_cnt <= 0 and `led` <= `led` ^ PATTERN.
- If not continuous: steps_left decrements; when steps_left was 1, go to IDLE and set done in the same cycle.
REQ-022 SHALL, in continuous mode, step indefinitely and never set done.
REQ-023 SHALL ignore a tick that coincides with the start write.
REQ-024 SHALL read DIVIDER and PATTERN live during RUN; a COUNT write during RUN affects only the next start.
REQ-025 SHALL let an LED write override a same-cycle step.
REQ-026 SHALL let a done set win over a same-cycle STATUS write clear.
REQ-027 SHALL drive `irq` = done & irq_en combinationally from registered bits.
REQ-028 SHALL keep div_cnt and steps_left at 16 bits; arithmetic SHALL never wrap below 0.

Reset
REQ-029 SHALL, on `reset_n` low, asynchronously set:
- state IDLE; `led` 0; `readdata` 0; `irq` 0; done 0; CONTROL 0.
- DIVIDER 1; COUNT 0; PATTERN 0x0001; TICKS 0; div_cnt 0; steps_left 0; tick delay 0.
REQ-030 SHALL, when reset is asserted mid-RUN, abort with no pending step after release.

Structure
REQ-031 SHALL place the register address constants, CONTROL/STATUS bit indices, and the FSM state encoding in shared package `ledtoggle_pkg`.
REQ-032 SHALL implement the tick edge detector as sub-module `ledtoggle_edge_detect` (rising-edge pulse, async reset); everything else SHALL stay flat.

Verification
REQ-033 Bench SHALL cover: DIVIDER=3, COUNT=2, PATTERN=0x0F, LED=0, start, 6 tick pulses -> `led` 0x0F after tick 3, 0x00 after tick 6; done=1; busy=0.
REQ-034 Bench SHALL cover: irq_en=1 plus REQ-033 -> `irq` rises in the cycle after tick 6's step; STATUS write -> `irq` 0 next cycle.
REQ-035 Bench SHALL cover: continuous=1, DIVIDER=0, PATTERN=0x01, 5 ticks -> `led` toggles every tick, ends 0x01, done stays 0; stop -> busy 0, no further toggles.
REQ-036 Bench SHALL cover: `tick_in` held high 10 cycles -> TICKS increments by 1; TICKS at 0xFFFF + 1 tick -> reads 0x0000.
REQ-037 Bench SHALL cover: COUNT=0 one-shot start -> done=1 after 1 cycle, `led` unchanged; start+stop in one write -> stays IDLE.
REQ-038 Bench SHALL cover: step coinciding with LED write 0xAA -> `led`=0xAA; reset asserted mid-RUN -> all REQ-029 values and busy 0.
